// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_out_slice.sv
// One-entry valid/ready register slice feeding a single demux output.
// A load and a drain in the same cycle replace the held word, so the slice
// sustains one word per cycle with no bubble.
module demux_out_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // Occupancy: set on load, cleared on drain unless refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            full <= 1'b0;
        else if (load)
            full <= 1'b1;
        else if (drain)
            full <= 1'b0;
    end

    // Data holds unless loaded; the top never loads a slice that is stalled full.
    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (load)
            data <= din;
    end

endmodule

// File: rtl/demux_stream_1to4.sv
// 1-to-4 stream demultiplexer with a registered one-entry slice per output.
// Optional feature macro: DEMUX_COUNT_EN adds per-output transfer counters
// on the out_cnt port.
module demux_stream_1to4
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  sel_t                      in_sel,
    input  logic [DATA_W-1:0]         in_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
`ifdef DEMUX_COUNT_EN
    output logic [NUM_OUT*CNT_W-1:0]  out_cnt,
`endif
    output logic [NUM_OUT*DATA_W-1:0] out_data
);

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] drain;
    logic               in_fire;

    // Input acceptance looks only at the addressed slice, so a stalled output
    // blocks only words routed to it. out_ready feeds through combinationally.
    always_comb begin
        in_ready = !full[in_sel] || out_ready[in_sel];
        in_fire  = in_valid && in_ready;
    end

    // Select decode and per-output drain handshakes.
    always_comb begin
        load  = '0;
        drain = full & out_ready;
        if (in_fire)
            load[in_sel] = 1'b1;
    end

    assign out_valid = full;

    genvar i;
    generate
        for (i = 0; i < NUM_OUT; i++) begin : g_slice
            demux_out_slice #(.DATA_W(DATA_W)) u_slice (
                .clk   (clk),
                .rst   (rst),
                .load  (load[i]),
                .drain (drain[i]),
                .din   (in_data),
                .full  (full[i]),
                .data  (out_data[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

`ifdef DEMUX_COUNT_EN
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt;

    // Per-output handshake counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            for (int k = 0; k < NUM_OUT; k++)
                if (drain[k])
                    cnt[k] <= cnt[k] + 1'b1;
    end

    assign out_cnt = cnt;
`else
    // Counter width only matters when counters are built.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Directed self-checking bench for demux_stream_1to4.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_demux_stream_1to4;
    localparam int DATA_W = 8;
`ifdef DEMUX_COUNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [4*DATA_W-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [4*CNT_W-1:0] out_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_stream_1to4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_COUNT_EN
        .out_cnt   (out_cnt),
`endif
        .out_data  (out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hFF; out_ready = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (out_valid !== 4'b0000) begin
                n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid);
            end
            n_checks++;
            if (out_data !== 32'h0) begin
                n_fail++; $display("FAIL reset_data: got %h expected 00000000", out_data);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_routing();
        logic [7:0] exp_d;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'hA0 + 8'(i);
            in_valid = 1'b1; in_sel = 2'(i); in_data = exp_d;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL route_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 4'(1 << i)) begin
                n_fail++; $display("FAIL route_valid[%0d]: got %b expected %b", i, out_valid, 4'(1 << i));
            end
            n_checks++;
            if (out_data[i*DATA_W +: DATA_W] !== exp_d) begin
                n_fail++; $display("FAIL route_data[%0d]: got %h expected %h", i, out_data[i*DATA_W +: DATA_W], exp_d);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL route_drained: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_backpressure_isolation();
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
        step();
        in_data = 8'h22;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
        step();
        n_checks++;
        if (out_valid[2] !== 1'b1 || out_data[16 +: 8] !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=11", out_valid[2], out_data[16 +: 8]);
        end
        // Output 2 still stalled: a word for output 1 must pass.
        in_sel = 2'd1; in_data = 8'h33;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL iso_in_ready: got %b expected 1", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0110 || out_data[8 +: 8] !== 8'h33 || out_data[16 +: 8] !== 8'h11) begin
            n_fail++; $display("FAIL iso_deliver: got v=%b d1=%h d2=%h expected v=0110 d1=33 d2=11",
                               out_valid, out_data[8 +: 8], out_data[16 +: 8]);
        end
        // Release output 2; the waiting 8'h22 goes in.
        out_ready = 4'b1111; in_sel = 2'd2; in_data = 8'h22;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0100 || out_data[16 +: 8] !== 8'h22) begin
            n_fail++; $display("FAIL bp_release_data: got v=%b d=%h expected v=0100 d=22", out_valid, out_data[16 +: 8]);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL bp_drained: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        int errs = 0;
        out_ready = 4'b1000;
        for (int k = 0; k < 16; k++) begin
            exp_d = 8'(k * 3 + 5);
            in_valid = 1'b1; in_sel = 2'd3; in_data = exp_d;
            #1;
            if (in_ready !== 1'b1) errs++;
            step();
            if (out_valid !== 4'b1000 || out_data[24 +: 8] !== exp_d) begin
                errs++;
                $display("FAIL stream_word[%0d]: got v=%b d=%h expected v=1000 d=%h", k, out_valid, out_data[24 +: 8], exp_d);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (errs != 0) begin
            n_fail++; $display("FAIL stream: got %0d bad cycles expected 0", errs);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL stream_drained: got %b expected 0000", out_valid);
        end
    endtask

`ifdef DEMUX_COUNT_EN
    task automatic test_counters();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_cnt !== 8'h00) begin
            n_fail++; $display("FAIL cnt_reset0: got %h expected 00", out_cnt);
        end
        out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_cnt !== 8'h01) begin
            n_fail++; $display("FAIL cnt_wrap: got %h expected 01", out_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_cnt !== 8'h00) begin
            n_fail++; $display("FAIL cnt_reset1: got %h expected 00", out_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        #1;
        test_reset();
        test_routing();
        test_backpressure_isolation();
        test_back_to_back();
`ifdef DEMUX_COUNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
